// File: rtl/hd44780_byte_sender.sv
// Splits one HD44780 command/data byte into two nybble transfers and then holds off for the LCD execution time.
// Optional HD44780_SINGLE_NYB_EN adds i_single to send only the high nybble (4-bit init sequence).
module hd44780_byte_sender #(
    parameter int CLK_HZ     = 12000000,
    parameter int SHORT_WAIT = CLK_HZ / 25000,
    parameter int LONG_WAIT  = (CLK_HZ / 100000) * 152
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       STB_I,
    input  logic       i_rs,
    input  logic [7:0] i_byte,
`ifdef HD44780_SINGLE_NYB_EN
    input  logic       i_single,
`endif
    output logic       o_busy,
    output logic       o_nyb_stb,
    output logic       o_nyb_rs,
    output logic [3:0] o_nyb_data,
    input  logic       i_nyb_busy
);

    localparam int CW = $clog2(LONG_WAIT + 1);
    localparam logic [CW-1:0] SHORT_LOAD = CW'(SHORT_WAIT - 1);
    localparam logic [CW-1:0] LONG_LOAD  = CW'(LONG_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        HI_STB,
        HI_WAIT,
        LO_STB,
        LO_WAIT,
        EXEC
    } state_t;

    state_t        state;
    logic [7:0]    byte_r;
    logic          rs_r;
    logic          stb_q;
    logic          seen_busy;
    logic [CW-1:0] count;
    logic          use_long;
`ifdef HD44780_SINGLE_NYB_EN
    logic          single_r;
`endif

    // Clear and return-home need the long execution time.
    always_comb begin
        use_long = 1'b0;
        if (!rs_r && (byte_r == 8'h01 || byte_r == 8'h02 || byte_r == 8'h03))
            use_long = 1'b1;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state      <= IDLE;
            byte_r     <= '0;
            rs_r       <= 1'b0;
            stb_q      <= 1'b0;
            seen_busy  <= 1'b0;
            count      <= '0;
            o_busy     <= 1'b0;
            o_nyb_stb  <= 1'b0;
            o_nyb_rs   <= 1'b0;
            o_nyb_data <= '0;
`ifdef HD44780_SINGLE_NYB_EN
            single_r   <= 1'b0;
`endif
        end else begin
            stb_q     <= STB_I;
            o_nyb_stb <= 1'b0;
            case (state)
                IDLE: begin
                    if (STB_I && !stb_q) begin
                        byte_r     <= i_byte;
                        rs_r       <= i_rs;
`ifdef HD44780_SINGLE_NYB_EN
                        single_r   <= i_single;
`endif
                        o_busy     <= 1'b1;
                        o_nyb_stb  <= 1'b1;
                        o_nyb_rs   <= i_rs;
                        o_nyb_data <= i_byte[7:4];
                        state      <= HI_STB;
                    end
                end
                HI_STB: begin
                    seen_busy <= 1'b0;
                    state     <= HI_WAIT;
                end
                HI_WAIT: begin
                    if (i_nyb_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
`ifdef HD44780_SINGLE_NYB_EN
                        if (single_r) begin
                            count <= SHORT_LOAD;
                            state <= EXEC;
                        end else
`endif
                        begin
                            o_nyb_stb  <= 1'b1;
                            o_nyb_data <= byte_r[3:0];
                            state      <= LO_STB;
                        end
                    end
                end
                LO_STB: begin
                    seen_busy <= 1'b0;
                    state     <= LO_WAIT;
                end
                LO_WAIT: begin
                    if (i_nyb_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        count <= use_long ? LONG_LOAD : SHORT_LOAD;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    // Loaded with wait-1 and exits on reading 0, so EXEC spans exactly wait cycles.
                    if (count == '0) begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hd44780_byte_sender.sv
// Scoreboard bench for hd44780_byte_sender with a behavioural nybble-sender responder.
module tb_hd44780_byte_sender;

    localparam int CLK_HZ = 12000000;
    localparam int SHORT  = CLK_HZ / 25000;
    localparam int LONG   = (CLK_HZ / 100000) * 152;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b0;
    logic       STB_I = 1'b0;
    logic       i_rs = 1'b0;
    logic [7:0] i_byte = '0;
    logic       o_busy;
    logic       o_nyb_stb;
    logic       o_nyb_rs;
    logic [3:0] o_nyb_data;
    logic       i_nyb_busy = 1'b0;
`ifdef HD44780_SINGLE_NYB_EN
    logic       i_single = 1'b0;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int stb_count = 0;

    logic [4:0] nyb_q[$];
    int         span_q[$];
    int         b_q[$];

    always #5 CLK_I = ~CLK_I;

    hd44780_byte_sender #(
        .CLK_HZ(CLK_HZ)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .STB_I     (STB_I),
        .i_rs      (i_rs),
        .i_byte    (i_byte),
`ifdef HD44780_SINGLE_NYB_EN
        .i_single  (i_single),
`endif
        .o_busy    (o_busy),
        .o_nyb_stb (o_nyb_stb),
        .o_nyb_rs  (o_nyb_rs),
        .o_nyb_data(o_nyb_data),
        .i_nyb_busy(i_nyb_busy)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Nybble-sender responder: busy rises the cycle after a strobe and stays high for B cycles.
    logic arm = 1'b0;
    int   arm_b = 0;
    int   rem = 0;

    always @(negedge CLK_I) begin
        if (!RST_I) begin
            b_q.delete();
            arm = 1'b0;
        end else if (o_nyb_stb) begin
            arm   = 1'b1;
            arm_b = (b_q.size() != 0) ? b_q.pop_front() : 3;
        end
    end

    always @(posedge CLK_I) begin
        #1;
        if (!RST_I) begin
            i_nyb_busy = 1'b0;
            rem = 0;
        end else if (arm) begin
            arm = 1'b0;
            rem = arm_b;
            i_nyb_busy = 1'b1;
        end else if (rem > 0) begin
            rem--;
            if (rem == 0) i_nyb_busy = 1'b0;
        end
    end

    // Monitor: checks each nybble strobe and the total length of each busy span.
    int span = 0;
    always @(negedge CLK_I) begin
        logic [4:0] e;
        if (!RST_I) begin
            nyb_q.delete();
            span_q.delete();
            span = 0;
        end else begin
            if (o_nyb_stb) begin
                stb_count++;
                if (nyb_q.size() == 0) begin
                    check("stb_unexpected", int'(o_nyb_stb), 0);
                end else begin
                    e = nyb_q.pop_front();
                    check("nyb_data", int'(o_nyb_data), int'(e[3:0]));
                    check("nyb_rs", int'(o_nyb_rs), int'(e[4]));
                end
            end
            if (o_busy) begin
                span++;
            end else if (span != 0) begin
                if (span_q.size() == 0) check("span_unexpected", span, 0);
                else check("busy_span", span, span_q.pop_front());
                span = 0;
            end
        end
    end

    function automatic int exp_wait(input bit rs, input logic [7:0] b, input bit single);
        if (!single && !rs && b >= 8'h01 && b <= 8'h03) return LONG;
        return SHORT;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK_I);
        while (o_busy && n < 40000) begin
            @(negedge CLK_I);
            n++;
        end
        if (o_busy) check("idle_timeout", int'(o_busy), 0);
    endtask

    task automatic expect_txn(input bit rs, input logic [7:0] b, input bit single,
                              input int b1, input int b2);
        int w;
        w = exp_wait(rs, b, single);
        nyb_q.push_back({rs, b[7:4]});
        b_q.push_back(b1);
        if (single) begin
            span_q.push_back(2 + b1 + w);
        end else begin
            nyb_q.push_back({rs, b[3:0]});
            b_q.push_back(b2);
            span_q.push_back(4 + b1 + b2 + w);
        end
    endtask

    task automatic send(input bit rs, input logic [7:0] b, input bit single,
                        input int b1, input int b2);
        wait_idle();
        expect_txn(rs, b, single, b1, b2);
        STB_I  = 1'b1;
        i_rs   = rs;
        i_byte = b;
`ifdef HD44780_SINGLE_NYB_EN
        i_single = single;
`endif
        @(negedge CLK_I);
        STB_I = 1'b0;
    endtask

    initial begin
        int c0;
        int n;
        bit rs;
        logic [7:0] b;

        #1;
        check("rst_busy", int'(o_busy), 0);
        check("rst_stb", int'(o_nyb_stb), 0);
        check("rst_rs", int'(o_nyb_rs), 0);
        check("rst_data", int'(o_nyb_data), 0);
        repeat (3) @(negedge CLK_I);
        RST_I = 1'b1;

        // Data byte and the clear/home wait selection boundaries.
        send(1'b1, 8'h4B, 1'b0, 2, 3);
        send(1'b0, 8'h01, 1'b0, 1, 1);
        send(1'b1, 8'h01, 1'b0, 4, 2);
        send(1'b0, 8'h00, 1'b0, 1, 5);
        send(1'b0, 8'h04, 1'b0, 3, 1);

        // Reset in the middle of EXEC.
        wait_idle();
        c0 = stb_count;
        send(1'b1, 8'hC3, 1'b0, 2, 2);
        n = 0;
        while (stb_count - c0 < 2 && n < 1000) begin
            @(negedge CLK_I);
            n++;
        end
        repeat (50) @(negedge CLK_I);
        #2;
        RST_I = 1'b0;
        #1;
        check("mid_rst_busy", int'(o_busy), 0);
        check("mid_rst_stb", int'(o_nyb_stb), 0);
        check("mid_rst_rs", int'(o_nyb_rs), 0);
        check("mid_rst_data", int'(o_nyb_data), 0);
        repeat (2) @(negedge CLK_I);
        #2;
        RST_I = 1'b1;
        @(negedge CLK_I);
        check("post_rst_busy", int'(o_busy), 0);
        send(1'b1, 8'h9E, 1'b0, 2, 2);

        // Held strobe sends exactly one byte.
        wait_idle();
        expect_txn(1'b1, 8'h28, 1'b0, 2, 2);
        c0 = stb_count;
        i_rs   = 1'b1;
        i_byte = 8'h28;
        STB_I  = 1'b1;
        repeat (30000) @(negedge CLK_I);
        STB_I = 1'b0;
        wait_idle();
        check("held_stb_pulses", stb_count - c0, 2);

        // Strobe arriving during LO_WAIT is ignored.
        wait_idle();
        c0 = stb_count;
        send(1'b1, 8'hA7, 1'b0, 2, 30);
        n = 0;
        while (stb_count - c0 < 2 && n < 1000) begin
            @(negedge CLK_I);
            n++;
        end
        check("first_byte_pulses", stb_count - c0, 2);
        repeat (3) @(negedge CLK_I);
        i_byte = 8'h55;
        STB_I  = 1'b1;
        @(negedge CLK_I);
        STB_I = 1'b0;
        wait_idle();
        check("busy_strobe_ignored", stb_count - c0, 2);
        send(1'b0, 8'h55, 1'b0, 3, 3);
        wait_idle();
        check("later_strobe_pulses", stb_count - c0, 4);

`ifdef HD44780_SINGLE_NYB_EN
        c0 = stb_count;
        send(1'b0, 8'h30, 1'b1, 3, 0);
        wait_idle();
        check("single_pulses", stb_count - c0, 1);
`endif

        // Randomized bytes; long-wait bytes are shifted to keep run time bounded.
        for (int k = 0; k < 20; k++) begin
            rs = 1'($urandom_range(0, 1));
            b  = 8'($urandom_range(0, 255));
            if (!rs && b >= 8'h01 && b <= 8'h03) b = b + 8'h10;
            send(rs, b, 1'b0, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
        end

        wait_idle();
        repeat (5) @(negedge CLK_I);
        check("nyb_q_left", nyb_q.size(), 0);
        check("span_q_left", span_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
